// File: rtl/mmc1_serial_mapper_if.sv
// Cartridge-side bus bundle for the MMC1-class serial mapper.
// Bus semantics: there is no valid/ready pair on this bundle. The CPU bus is
// qualified by m2: a cycle with cpu_addr[15]=1 and cpu_rw=0 is a register
// write and is sampled on the falling edge of m2. All memory-side outputs are
// combinational functions of the current address plus registered mapper
// state. The save-state port writes on the falling edge of m2 when sst_we=1,
// and sst_data_out always reflects the register selected by sst_addr.
interface mmc1_serial_mapper_if #(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5,
  parameter int OUTER_PRG     = 0
);
  localparam int PRG_AW = PRG_BANK_BITS + OUTER_PRG + 14;
  localparam int CHR_AW = CHR_BANK_BITS + 12;

  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_data_in;
  logic              cpu_rw;
  logic [13:0]       ppu_addr;
  logic              ppu_rd;
  logic              ppu_wr;
  logic              chr_ram;
  logic [PRG_AW-1:0] prg_addr;
  logic              prg_oe;
  logic              prg_we;
  logic              wram_ce;
  logic [CHR_AW-1:0] chr_addr;
  logic              chr_oe;
  logic              chr_we;
  logic              ciram_ce;
  logic              ciram_a10;
  logic              sst_enable;
  logic              sst_we;
  logic [2:0]        sst_addr;
  logic [7:0]        sst_data_in;
  logic [7:0]        sst_data_out;

  // Console / save-state controller side.
  modport master (
    output cpu_addr, cpu_data_in, cpu_rw, ppu_addr, ppu_rd, ppu_wr, chr_ram,
    output sst_enable, sst_we, sst_addr, sst_data_in,
    input  prg_addr, prg_oe, prg_we, wram_ce, chr_addr, chr_oe, chr_we,
    input  ciram_ce, ciram_a10, sst_data_out
  );

  // Mapper side.
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_rw, ppu_addr, ppu_rd, ppu_wr, chr_ram,
    input  sst_enable, sst_we, sst_addr, sst_data_in,
    output prg_addr, prg_oe, prg_we, wram_ce, chr_addr, chr_oe, chr_we,
    output ciram_ce, ciram_a10, sst_data_out
  );
endinterface

// File: rtl/mmc1_serial_mapper.sv
// MMC1-class serial-load bank mapper: a shift register loaded one bit per CPU
// write commits whole words into control/CHR/PRG bank registers, which then
// steer PRG, WRAM, CHR and CIRAM addressing. All state changes on falling m2.
module mmc1_serial_mapper #(
  parameter int SHIFT_BITS    = 5,
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5,
  parameter int OUTER_PRG     = 0,
  parameter int WRAM_BITS     = 13
) (
  input logic m2,
  input logic reset_n,
  mmc1_serial_mapper_if.slave bus
);
  localparam int CNT_BITS = $clog2(SHIFT_BITS);
  localparam int PRG_AW   = PRG_BANK_BITS + OUTER_PRG + 14;

  logic [SHIFT_BITS-1:0]    shift;
  logic [SHIFT_BITS-1:0]    chr_bank_0;
  logic [SHIFT_BITS-1:0]    chr_bank_1;
  logic [SHIFT_BITS-1:0]    prg_bank;
  logic [CNT_BITS-1:0]      count;
  logic [4:0]               control;
  logic                     prev_wr;

  logic                     chr_mode;
  logic [1:0]               prg_mode;
  logic [1:0]               mirror;
  logic                     wr_cycle;
  logic [SHIFT_BITS-1:0]    next_word;
  logic [PRG_BANK_BITS-1:0] prg_lo;
  logic [PRG_BANK_BITS-1:0] prg_sel;
  logic [PRG_AW-15:0]       prg_bank_full;
  logic [CHR_BANK_BITS-1:0] chr_sel;
  logic                     unused_bits;

  assign chr_mode  = control[4];
  assign prg_mode  = control[3:2];
  assign mirror    = control[1:0];
  assign wr_cycle  = bus.cpu_addr[15] & ~bus.cpu_rw;
  // Incoming bit enters at the MSB, so the first bit written ends up as bit 0.
  assign next_word = {bus.cpu_data_in[0], shift[SHIFT_BITS-1:1]};

  // Serial loader, register commit, RMW filter and save-state writes.
  always_ff @(negedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      shift      <= '0;
      count      <= '0;
      control    <= 5'b01100;
      chr_bank_0 <= '0;
      chr_bank_1 <= '0;
      prg_bank   <= '0;
      prev_wr    <= 1'b0;
    end else begin
      prev_wr <= wr_cycle;
      if (bus.sst_we) begin
        case (bus.sst_addr)
          3'd0:    shift      <= bus.sst_data_in[SHIFT_BITS-1:0];
          3'd1:    count      <= bus.sst_data_in[CNT_BITS-1:0];
          3'd2:    control    <= bus.sst_data_in[4:0];
          3'd3:    chr_bank_0 <= bus.sst_data_in[SHIFT_BITS-1:0];
          3'd4:    chr_bank_1 <= bus.sst_data_in[SHIFT_BITS-1:0];
          3'd5:    prg_bank   <= bus.sst_data_in[SHIFT_BITS-1:0];
          3'd6:    prev_wr    <= bus.sst_data_in[0];
          default: ;
        endcase
      end else if (!bus.sst_enable && wr_cycle) begin
        if (bus.cpu_data_in[7]) begin
          // Reset write is honoured even on the second cycle of an RMW.
          shift        <= '0;
          count        <= '0;
          control[3:2] <= 2'b11;
        end else if (!prev_wr) begin
          if (count == CNT_BITS'(SHIFT_BITS - 1)) begin
            shift <= '0;
            count <= '0;
            case (bus.cpu_addr[14:13])
              2'd0:    control    <= 5'(next_word);
              2'd1:    chr_bank_0 <= next_word;
              2'd2:    chr_bank_1 <= next_word;
              default: prg_bank   <= next_word;
            endcase
          end else begin
            shift <= next_word;
            count <= count + 1'b1;
          end
        end
      end
    end
  end

  assign prg_lo = prg_bank[PRG_BANK_BITS-1:0];

  // PRG 16 KiB bank selection by mode and CPU window.
  always_comb begin
    prg_sel = prg_lo;
    case (prg_mode)
      2'd0, 2'd1: prg_sel = {prg_lo[PRG_BANK_BITS-1:1], bus.cpu_addr[14]};
      2'd2:       prg_sel = bus.cpu_addr[14] ? prg_lo : '0;
      default:    prg_sel = bus.cpu_addr[14] ? '1 : prg_lo;
    endcase
  end

  // The outer bit sits above the whole field, so fixed banks stay in the current half.
  generate
    if (OUTER_PRG != 0) begin : g_outer
      assign prg_bank_full = {chr_bank_0[SHIFT_BITS-1], prg_sel};
    end else begin : g_flat
      assign prg_bank_full = prg_sel;
    end
  endgenerate

  assign bus.wram_ce  = (bus.cpu_addr[15:13] == 3'b011) & ~prg_bank[SHIFT_BITS-1];
  assign bus.prg_addr = bus.wram_ce ? PRG_AW'(bus.cpu_addr[WRAM_BITS-1:0])
                                    : {prg_bank_full, bus.cpu_addr[13:0]};
  assign bus.prg_oe   = bus.cpu_rw & (bus.cpu_addr[15] | bus.wram_ce);
  assign bus.prg_we   = ~bus.cpu_rw & bus.wram_ce;

  // CHR 4 KiB bank selection; CHR RAM ignores the bank registers.
  always_comb begin
    chr_sel = {chr_bank_0[CHR_BANK_BITS-1:1], bus.ppu_addr[12]};
    if (bus.chr_ram)
      chr_sel = {{(CHR_BANK_BITS-1){1'b0}}, bus.ppu_addr[12]};
    else if (chr_mode)
      chr_sel = bus.ppu_addr[12] ? chr_bank_1[CHR_BANK_BITS-1:0]
                                 : chr_bank_0[CHR_BANK_BITS-1:0];
  end

  assign bus.chr_addr = {chr_sel, bus.ppu_addr[11:0]};
  assign bus.chr_oe   = ~bus.ppu_rd;
  assign bus.chr_we   = bus.chr_ram & ~bus.ppu_wr;
  assign bus.ciram_ce = ~bus.ppu_addr[13];

  // Nametable mirroring: one-screen low/high, vertical, horizontal.
  always_comb begin
    bus.ciram_a10 = 1'b0;
    case (mirror)
      2'd0:    bus.ciram_a10 = 1'b0;
      2'd1:    bus.ciram_a10 = 1'b1;
      2'd2:    bus.ciram_a10 = bus.ppu_addr[10];
      default: bus.ciram_a10 = bus.ppu_addr[11];
    endcase
  end

  // Save-state readback; doubles as the debug view of all mapper state.
  always_comb begin
    bus.sst_data_out = 8'hFF;
    case (bus.sst_addr)
      3'd0:    bus.sst_data_out = 8'(shift);
      3'd1:    bus.sst_data_out = 8'(count);
      3'd2:    bus.sst_data_out = 8'(control);
      3'd3:    bus.sst_data_out = 8'(chr_bank_0);
      3'd4:    bus.sst_data_out = 8'(chr_bank_1);
      3'd5:    bus.sst_data_out = 8'(prg_bank);
      3'd6:    bus.sst_data_out = {7'd0, prev_wr};
      default: bus.sst_data_out = 8'hFF;
    endcase
  end

  // Data bits 6:1 carry no meaning to this mapper.
  assign unused_bits = ^{bus.cpu_data_in[6:1], bus.sst_data_in, chr_bank_0, prg_bank};
endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Bench for mmc1_serial_mapper: two instances (flat and outer-PRG) share one
// stimulus stream; expected outputs are queued and checked by a monitor.
module tb_mmc1_serial_mapper;
  localparam int SEL_PRG0 = 0;
  localparam int SEL_PRG1 = 1;
  localparam int SEL_CHR0 = 2;
  localparam int SEL_SST0 = 3;
  localparam int SEL_CTL0 = 4;

  logic        m2;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_rw;
  logic [13:0] ppu_addr;
  logic        ppu_rd;
  logic        ppu_wr;
  logic        chr_ram;
  logic        sst_enable;
  logic        sst_we;
  logic [2:0]  sst_addr;
  logic [7:0]  sst_data_in;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passes = 0;

  mmc1_serial_mapper_if #(.OUTER_PRG(0)) bus0 ();
  mmc1_serial_mapper_if #(.OUTER_PRG(1)) bus1 ();

  assign bus0.cpu_addr = cpu_addr;     assign bus1.cpu_addr = cpu_addr;
  assign bus0.cpu_data_in = cpu_data_in; assign bus1.cpu_data_in = cpu_data_in;
  assign bus0.cpu_rw = cpu_rw;         assign bus1.cpu_rw = cpu_rw;
  assign bus0.ppu_addr = ppu_addr;     assign bus1.ppu_addr = ppu_addr;
  assign bus0.ppu_rd = ppu_rd;         assign bus1.ppu_rd = ppu_rd;
  assign bus0.ppu_wr = ppu_wr;         assign bus1.ppu_wr = ppu_wr;
  assign bus0.chr_ram = chr_ram;       assign bus1.chr_ram = chr_ram;
  assign bus0.sst_enable = sst_enable; assign bus1.sst_enable = sst_enable;
  assign bus0.sst_we = sst_we;         assign bus1.sst_we = sst_we;
  assign bus0.sst_addr = sst_addr;     assign bus1.sst_addr = sst_addr;
  assign bus0.sst_data_in = sst_data_in; assign bus1.sst_data_in = sst_data_in;

  mmc1_serial_mapper u_dut0 (.m2(m2), .reset_n(reset_n), .bus(bus0));
  mmc1_serial_mapper #(.OUTER_PRG(1)) u_dut1 (.m2(m2), .reset_n(reset_n), .bus(bus1));

  // Clock and reset.
  initial begin
    m2 = 1'b0;
    forever #5 m2 = ~m2;
  end

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_PRG0: return 32'(bus0.prg_addr);
      SEL_PRG1: return 32'(bus1.prg_addr);
      SEL_CHR0: return 32'(bus0.chr_addr);
      SEL_SST0: return 32'(bus0.sst_data_out);
      default:  return 32'({bus0.prg_oe, bus0.prg_we, bus0.wram_ce, bus0.chr_oe,
                            bus0.chr_we, bus0.ciram_ce, bus0.ciram_a10});
    endcase
  endfunction

  // Monitor: samples on rising m2, away from the falling active edge.
  initial begin
    logic [31:0] exp_v;
    logic [31:0] act_v;
    int          sel_v;
    string       nm;
    forever begin
      @(posedge m2);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        sel_v = sel_q.pop_front();
        nm    = name_q.pop_front();
        act_v = actual(sel_v);
        checks++;
        if (act_v === exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act_v, exp_v);
      end
    end
  end

  // Driver tasks: all input changes happen 1 time unit after a falling edge.
  task automatic expect_out(input int sel, input logic [31:0] exp_v, input string nm);
    int n;
    exp_q.push_back(exp_v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
    n = 0;
    do begin
      @(negedge m2);
      #1;
      n++;
    end while (exp_q.size() > 0 && n < 20);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL %s: monitor timeout, got no sample expected 0x%0h", nm, exp_v);
      exp_q.delete();
      sel_q.delete();
      name_q.delete();
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit gap);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_rw      = 1'b0;
    @(negedge m2);
    #1;
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0000;
    if (gap) begin
      @(negedge m2);
      #1;
    end
  endtask

  task automatic serial_load(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) cpu_write(a, {7'd0, v[i]}, 1'b1);
  endtask

  task automatic sst_write(input logic [2:0] idx, input logic [7:0] d);
    sst_addr    = idx;
    sst_data_in = d;
    sst_we      = 1'b1;
    @(negedge m2);
    #1;
    sst_we = 1'b0;
  endtask

  task automatic sst_check(input logic [2:0] idx, input logic [7:0] v, input string nm);
    sst_addr = idx;
    expect_out(SEL_SST0, 32'(v), nm);
  endtask

  task automatic prg_check(input int sel, input logic [15:0] a, input logic [31:0] v,
                           input string nm);
    cpu_addr = a;
    cpu_rw   = 1'b1;
    expect_out(sel, v, nm);
  endtask

  // Directed sequence.
  initial begin
    reset_n = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_rw = 1'b1;
    ppu_addr = 14'h0000; ppu_rd = 1'b1; ppu_wr = 1'b1; chr_ram = 1'b0;
    sst_enable = 1'b0; sst_we = 1'b0; sst_addr = 3'd0; sst_data_in = 8'h00;
    #22 reset_n = 1'b1;
    @(negedge m2);
    #1;

    // Reset state.
    sst_check(3'd2, 8'h0C, "rst_control");
    sst_check(3'd5, 8'h00, "rst_prg_bank");
    sst_check(3'd7, 8'hFF, "sst_idx7");
    prg_check(SEL_PRG0, 16'hC000, 32'h3C000, "rst_prg_c000");
    prg_check(SEL_PRG0, 16'h8000, 32'h00000, "rst_prg_8000");

    // Hardware reset mid-sequence drops the partial word.
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h01, 1'b1);
    sst_check(3'd1, 8'h02, "partial_count");
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    sst_check(3'd1, 8'h00, "reset_mid_count");
    sst_check(3'd0, 8'h00, "reset_mid_shift");

    // Reset write.
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'h8000, 8'h80, 1'b1);
    sst_check(3'd2, 8'h0C, "resetwr_control");
    sst_check(3'd1, 8'h00, "resetwr_count");
    prg_check(SEL_PRG0, 16'hC000, 32'h3C000, "resetwr_prg_c000");

    // PRG bank load, mode 3, WRAM.
    serial_load(16'hE000, 5'h05);
    sst_check(3'd5, 8'h05, "prg_bank_load");
    prg_check(SEL_PRG0, 16'h8000, 32'h14000, "prg_mode3_8000");
    prg_check(SEL_PRG0, 16'h6123, 32'h00123, "wram_addr");
    expect_out(SEL_CTL0, 32'h52, "wram_read_ctl");
    cpu_rw = 1'b0;
    expect_out(SEL_CTL0, 32'h32, "wram_write_ctl");
    cpu_rw = 1'b1;

    // RMW filter: writes 2 and 3 on back-to-back edges.
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h00, 1'b0);
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h00, 1'b1);
    cpu_write(16'hE000, 8'h00, 1'b1);
    sst_check(3'd1, 8'h04, "rmw_count");
    sst_check(3'd0, 8'h02, "rmw_shift");
    sst_check(3'd5, 8'h05, "rmw_no_commit");
    cpu_write(16'h8000, 8'h80, 1'b1);

    // CHR banking.
    serial_load(16'h8000, 5'h10);
    serial_load(16'hA000, 5'h03);
    serial_load(16'hC000, 5'h1E);
    ppu_rd = 1'b0;
    ppu_addr = 14'h0800;
    expect_out(SEL_CHR0, 32'h03800, "chr_mode1_lo");
    ppu_addr = 14'h1800;
    expect_out(SEL_CHR0, 32'h1E800, "chr_mode1_hi");
    chr_ram = 1'b1;
    expect_out(SEL_CHR0, 32'h01800, "chr_ram_hi");
    ppu_wr = 1'b0;
    expect_out(SEL_CTL0, 32'h0E, "chr_ram_write_ctl");
    ppu_wr = 1'b1;
    chr_ram = 1'b0;
    prg_check(SEL_PRG0, 16'h8000, 32'h10000, "prg_mode0_8000");
    prg_check(SEL_PRG0, 16'hC000, 32'h14000, "prg_mode0_c000");
    cpu_addr = 16'h0000;

    // chr_mode 0, prg_mode 2, mirroring.
    serial_load(16'h8000, 5'h0B);
    expect_out(SEL_CHR0, 32'h03800, "chr_mode0_hi");
    prg_check(SEL_PRG0, 16'h8123, 32'h00123, "prg_mode2_8000");
    prg_check(SEL_PRG0, 16'hC000, 32'h14000, "prg_mode2_c000");
    cpu_addr = 16'h0000;
    ppu_addr = 14'h2800;
    expect_out(SEL_CTL0, 32'h09, "mirror_h_2800");
    ppu_addr = 14'h2400;
    expect_out(SEL_CTL0, 32'h08, "mirror_h_2400");
    serial_load(16'h8000, 5'h0A);
    expect_out(SEL_CTL0, 32'h09, "mirror_v_2400");

    // Outer PRG bit.
    serial_load(16'h8000, 5'h0C);
    serial_load(16'hA000, 5'h10);
    prg_check(SEL_PRG1, 16'hC000, 32'h7C000, "outer_c000");
    prg_check(SEL_PRG1, 16'h8000, 32'h54000, "outer_8000");
    prg_check(SEL_PRG0, 16'hC000, 32'h3C000, "flat_c000");
    cpu_addr = 16'h0000;
    serial_load(16'hA000, 5'h00);
    prg_check(SEL_PRG1, 16'hC000, 32'h3C000, "outer_c000_low");
    cpu_addr = 16'h0000;

    // Save-state access.
    ppu_addr = 14'h0000; ppu_rd = 1'b1; ppu_wr = 1'b1;
    cpu_write(16'h8000, 8'h80, 1'b1);
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h01, 1'b1);
    cpu_write(16'hE000, 8'h00, 1'b1);
    sst_enable = 1'b1;
    sst_check(3'd1, 8'h03, "sst_count_read");
    sst_check(3'd0, 8'h0C, "sst_shift_read");
    sst_write(3'd1, 8'h04);
    cpu_write(16'hE000, 8'h00, 1'b1);
    sst_check(3'd1, 8'h04, "sst_count_write");
    sst_write(3'd6, 8'h01);
    sst_check(3'd6, 8'h01, "sst_prev_wr");
    sst_enable = 1'b0;
    cpu_write(16'hE000, 8'h01, 1'b1);
    sst_check(3'd5, 8'h16, "sst_commit_prg");
    sst_check(3'd1, 8'h00, "sst_commit_count");
    prg_check(SEL_PRG0, 16'h8000, 32'h18000, "prg_after_commit");
    prg_check(SEL_CTL0, 16'h6000, 32'h02, "wram_protect_ctl");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
